// File: rtl/arp_tx_engine_pkg.sv
// ============================================================================
// Module   : arp_pkg
// Purpose  : ARP field constants, frame lengths and scheduler state encoding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package arp_pkg;

   localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
   localparam logic [15:0] HTYPE_ETH     = 16'h0001;
   localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
   localparam logic [15:0] OPER_REQ      = 16'h0001;
   localparam logic [15:0] OPER_REP      = 16'h0002;

   localparam int ARP_LEN     = 42;
   localparam int ETH_MIN_LEN = 60;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } arp_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arp_tx_engine_if.sv
// ============================================================================
// Module   : arp_tx_engine_if
// Purpose  : Byte-width-generic packet stream with valid/ready and empty count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface arp_tx_engine_if #(
   parameter int DATA_W = 16,
   parameter int MTY_W  = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
);
   logic [DATA_W-1:0] tx_arp_data;
   logic              tx_arp_vld;
   logic              tx_arp_sop;
   logic              tx_arp_eop;
   logic [MTY_W-1:0]  tx_arp_mty;
   logic              tx_arp_rdy;

   modport master (
      output tx_arp_data, tx_arp_vld, tx_arp_sop, tx_arp_eop, tx_arp_mty,
      input  tx_arp_rdy
   );

   modport slave (
      input  tx_arp_data, tx_arp_vld, tx_arp_sop, tx_arp_eop, tx_arp_mty,
      output tx_arp_rdy
   );
endinterface

`default_nettype wire

// File: rtl/arp_tx_engine_ack_fifo.sv
// ============================================================================
// Module   : arp_ack_fifo
// Purpose  : Pending-reply queue; a push into a full queue succeeds only when
//            a pop happens in the same cycle, otherwise it is dropped.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arp_ack_fifo
   import arp_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] din,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  drop
);
   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               r_drop;
   logic               w_pop_ok;
   logic               w_push_ok;

   assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);
   assign dout      = r_mem[r_rd_ptr];
   assign drop      = r_drop;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_drop <= push && !w_push_ok;
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/arp_tx_engine.sv
// ============================================================================
// Module   : arp_tx_engine
// Purpose  : Periodic/on-demand ARP request and queued ARP reply transmitter.
//            Define ARP_PAD_EN to pad frames to the Ethernet minimum length.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arp_tx_engine
   import arp_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int MAC_ADDR_W = 48,
   parameter int IP_ADDR_W  = 32,
   parameter int REQ_PERIOD = 100000000,
   parameter int ACK_DEPTH  = 4,
   parameter int MTY_W      = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic [MAC_ADDR_W-1:0] cfg_mac_s,
   input  wire logic [IP_ADDR_W-1:0]  cfg_sip,
   input  wire logic [IP_ADDR_W-1:0]  cfg_dip,
   input  wire logic                  req_en,
   input  wire logic                  resolved,
   input  wire logic                  ack_en,
   input  wire logic [MAC_ADDR_W-1:0] ack_mac_d,
   input  wire logic [IP_ADDR_W-1:0]  ack_ip_d,
   output logic                       ack_drop,
   arp_tx_engine_if.master            tx
);
   localparam int c_BYTES     = DATA_W / 8;
   localparam int c_CONT_BITS = 4*MAC_ADDR_W + 2*IP_ADDR_W + 80;
   localparam int c_CONT_LEN  = c_CONT_BITS / 8;
`ifdef ARP_PAD_EN
   localparam int c_LEN       = max_int(c_CONT_LEN, ETH_MIN_LEN);
`else
   localparam int c_LEN       = c_CONT_LEN;
`endif
   localparam int c_BEATS     = (c_LEN + c_BYTES - 1) / c_BYTES;
   localparam int c_MTY       = c_BEATS*c_BYTES - c_LEN;
   localparam int c_FRAME_W   = c_BEATS * DATA_W;
   localparam int c_IDX_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
   localparam int c_TMR_W     = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;
   localparam int c_ENTRY_W   = MAC_ADDR_W + IP_ADDR_W;

   localparam logic [7:0]       c_HLEN    = 8'(MAC_ADDR_W / 8);
   localparam logic [7:0]       c_PLEN    = 8'(IP_ADDR_W / 8);
   localparam logic [MTY_W-1:0] c_MTY_V   = MTY_W'(c_MTY);
   localparam logic [0:0]       c_ST_IDLE = ST_IDLE;
   localparam logic [0:0]       c_ST_SEND = ST_SEND;

   logic [0:0]            r_state;
   logic [c_TMR_W-1:0]    r_tmr;
   logic                  r_req_pend;
   logic [c_FRAME_W-1:0]  r_frame;
   logic [c_IDX_W-1:0]    r_idx;
   logic                  r_vld;
   logic                  r_sop;
   logic                  r_eop;
   logic [MTY_W-1:0]      r_mty;

   logic                  w_wrap;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [c_ENTRY_W-1:0]  w_fifo_dout;
   logic [MAC_ADDR_W-1:0] w_q_mac;
   logic [IP_ADDR_W-1:0]  w_q_ip;
   logic                  w_reply;
   logic                  w_launch;
   logic                  w_pop;
   logic                  w_req_set;
   logic                  w_req_clr;
   logic [MAC_ADDR_W-1:0] w_dmac;
   logic [MAC_ADDR_W-1:0] w_tha;
   logic [IP_ADDR_W-1:0]  w_tpa;
   logic [15:0]           w_oper;
   logic [c_FRAME_W-1:0]  w_frame;

   arp_ack_fifo #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (ACK_DEPTH)
   ) u_ack_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ack_en),
      .din   ({ack_mac_d, ack_ip_d}),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .drop  (ack_drop)
   );

   assign {w_q_mac, w_q_ip} = w_fifo_dout;

   // Replies win over a pending request; a request launch consumes req_pend.
   assign w_reply   = !w_fifo_empty;
   assign w_launch  = (r_state == c_ST_IDLE) && (w_reply || r_req_pend);
   assign w_pop     = w_launch && w_reply;
   assign w_req_clr = w_launch && !w_reply;
   assign w_wrap    = (r_tmr == c_TMR_W'(REQ_PERIOD - 1));
   assign w_req_set = req_en || (w_wrap && !resolved);

   assign w_dmac = w_reply ? w_q_mac : '1;
   assign w_tha  = w_reply ? w_q_mac : '0;
   assign w_tpa  = w_reply ? w_q_ip  : cfg_dip;
   assign w_oper = w_reply ? OPER_REP : OPER_REQ;

   // Frame is left-aligned so beats leave MSB-first; the tail stays zero.
   always_comb begin
      w_frame = '0;
      w_frame[c_FRAME_W-1 -: c_CONT_BITS] = {w_dmac, cfg_mac_s, ETHERTYPE_ARP,
         HTYPE_ETH, PTYPE_IPV4, c_HLEN, c_PLEN, w_oper,
         cfg_mac_s, cfg_sip, w_tha, w_tpa};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmr      <= '0;
         r_req_pend <= 1'b0;
      end else begin
         r_tmr      <= w_wrap ? '0 : r_tmr + c_TMR_W'(1);
         r_req_pend <= w_req_set ? 1'b1 : (w_req_clr ? 1'b0 : r_req_pend);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
         r_frame <= '0;
         r_idx   <= '0;
         r_vld   <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_mty   <= '0;
      end else if (r_state == c_ST_IDLE) begin
         if (w_launch) begin
            r_state <= c_ST_SEND;
            r_frame <= w_frame;
            r_idx   <= '0;
            r_vld   <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= (c_BEATS == 1);
            r_mty   <= (c_BEATS == 1) ? c_MTY_V : '0;
         end
      end else if (tx.tx_arp_rdy) begin
         if (r_eop) begin
            r_state <= c_ST_IDLE;
            r_frame <= '0;
            r_vld   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_mty   <= '0;
         end else begin
            r_frame <= r_frame << DATA_W;
            r_idx   <= r_idx + c_IDX_W'(1);
            r_sop   <= 1'b0;
            r_eop   <= (r_idx == c_IDX_W'(c_BEATS - 2));
            r_mty   <= (r_idx == c_IDX_W'(c_BEATS - 2)) ? c_MTY_V : '0;
         end
      end
   end

   assign tx.tx_arp_data = r_frame[c_FRAME_W-1 -: DATA_W];
   assign tx.tx_arp_vld  = r_vld;
   assign tx.tx_arp_sop  = r_sop;
   assign tx.tx_arp_eop  = r_eop;
   assign tx.tx_arp_mty  = r_mty;

endmodule

`default_nettype wire

// File: tb/tb_arp_tx_engine.sv
// ============================================================================
// Module   : tb_arp_tx_engine
// Purpose  : Randomized self-checking bench for arp_tx_engine (DATA_W=32).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arp_tx_engine;
   localparam int DW    = 32;
   localparam int MW    = 2;
   localparam int P     = 50;
   localparam int DEPTH = 4;
   localparam int BW    = DW / 8;
`ifdef ARP_PAD_EN
   localparam int L     = 60;
`else
   localparam int L     = 42;
`endif
   localparam int NB    = (L + BW - 1) / BW;
   localparam int EMTY  = NB*BW - L;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] cmac = 48'h0A0B0C0D0E0F;
   logic [31:0] csip = 32'hC0A80001;
   logic [31:0] cdip = 32'hC0A800FE;
   logic        req_en = 1'b0;
   logic        resolved = 1'b0;
   logic        ack_en = 1'b0;
   logic [47:0] ack_mac = '0;
   logic [31:0] ack_ip = '0;
   logic        ack_drop;
   logic        rdy = 1'b0;
   int          rdy_mode = 1;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;

   arp_tx_engine_if #(.DATA_W(DW), .MTY_W(MW)) tx_if ();
   assign tx_if.tx_arp_rdy = rdy;

   arp_tx_engine #(
      .DATA_W(DW), .MAC_ADDR_W(48), .IP_ADDR_W(32),
      .REQ_PERIOD(P), .ACK_DEPTH(DEPTH), .MTY_W(MW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_mac_s(cmac), .cfg_sip(csip), .cfg_dip(cdip),
      .req_en(req_en), .resolved(resolved), .ack_en(ack_en),
      .ack_mac_d(ack_mac), .ack_ip_d(ack_ip), .ack_drop(ack_drop), .tx(tx_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         default: rdy = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference frame: the ARP byte list laid out field by field.
   byte unsigned mq[$];
   function automatic void put(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) mq.push_back(v[8*i +: 8]);
   endfunction

   function automatic logic [511:0] model_frame(input bit reply, input logic [47:0] tmac,
         input logic [31:0] tip, input logic [47:0] smac, input logic [31:0] sip,
         input logic [31:0] dip);
      logic [511:0] v;
      v = '0;
      mq.delete();
      put(reply ? 64'(tmac) : 64'hFFFF_FFFF_FFFF, 6);
      put(64'(smac), 6);
      put(64'h0806, 2);
      put(64'h0001, 2);
      put(64'h0800, 2);
      put(64'd6, 1);
      put(64'd4, 1);
      put(reply ? 64'd2 : 64'd1, 2);
      put(64'(smac), 6);
      put(64'(sip), 4);
      put(reply ? 64'(tmac) : 64'd0, 6);
      put(reply ? 64'(tip) : 64'(dip), 4);
      while (mq.size() < L) put(64'd0, 1);
      for (int i = 0; i < mq.size(); i++) v[511 - 8*i -: 8] = mq[i];
      return v;
   endfunction

   logic [511:0] exp_q[$];
   int           start_q[$];
   int           end_q[$];
   int           frames_rx = 0;
   int           drop_cnt = 0;
   int           in_beats = 0;
   bit           in_frame = 0;
   bit           hold_pend = 0;
   logic [63:0]  held;
   logic [511:0] got;
   int           nbytes = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0; in_beats = 0; hold_pend = 0; got = '0; nbytes = 0;
      end else begin
         if (ack_drop) drop_cnt++;
         if (hold_pend && tx_if.tx_arp_vld)
            chk("hold", 512'({tx_if.tx_arp_data, tx_if.tx_arp_sop, tx_if.tx_arp_eop, tx_if.tx_arp_mty}),
                512'(held));
         hold_pend = 0;
         if (tx_if.tx_arp_vld && !in_frame) begin
            in_frame = 1;
            start_q.push_back(cyc);
         end
         if (tx_if.tx_arp_vld && !rdy) begin
            hold_pend = 1;
            held = 64'({tx_if.tx_arp_data, tx_if.tx_arp_sop, tx_if.tx_arp_eop, tx_if.tx_arp_mty});
         end
         if (tx_if.tx_arp_vld && rdy) begin
            chk("sop", 512'(tx_if.tx_arp_sop), 512'(in_beats == 0));
            chk("eop", 512'(tx_if.tx_arp_eop), 512'(in_beats == NB - 1));
            chk("mty", 512'(tx_if.tx_arp_mty), 512'((in_beats == NB - 1) ? EMTY : 0));
            for (int b = 0; b < BW; b++) begin
               if (!tx_if.tx_arp_eop || b < BW - int'(tx_if.tx_arp_mty)) begin
                  if (nbytes < 64) got[511 - 8*nbytes -: 8] = tx_if.tx_arp_data[DW - 1 - 8*b -: 8];
                  nbytes++;
               end else begin
                  chk("pad_byte", 512'(tx_if.tx_arp_data[DW - 1 - 8*b -: 8]), 512'(0));
               end
            end
            in_beats++;
            if (tx_if.tx_arp_eop) begin
               chk("len", 512'(nbytes), 512'(L));
               if (exp_q.size() == 0) chk("unexpected_frame", 512'(1), 512'(0));
               else chk("frame", got, exp_q.pop_front());
               end_q.push_back(cyc);
               frames_rx++;
               in_frame = 0; in_beats = 0; got = '0; nbytes = 0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_vld(output int lat);
      lat = -1;
      for (int i = 1; i <= 500; i++) begin
         @(posedge clk); #1;
         if (tx_if.tx_arp_vld) begin lat = i; break; end
      end
      if (lat < 0) chk("vld_timeout", 512'(0), 512'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 3000) begin tick(1); n++; end
      if (n >= 3000) chk("drain_timeout", 512'(exp_q.size()), 512'(0));
   endtask

   task automatic send_ack(input logic [47:0] m, input logic [31:0] ip);
      ack_en = 1'b1; ack_mac = m; ack_ip = ip;
      tick(1);
      ack_en = 1'b0;
   endtask

   initial begin
      int lat, k, n0, d0, gap;
      logic [47:0] m;
      logic [31:0] ip;

      // Reset state
      tick(3);
      chk("rst_vld", 512'(tx_if.tx_arp_vld), 512'(0));
      chk("rst_sop", 512'(tx_if.tx_arp_sop), 512'(0));
      chk("rst_eop", 512'(tx_if.tx_arp_eop), 512'(0));
      chk("rst_mty", 512'(tx_if.tx_arp_mty), 512'(0));
      chk("rst_data", 512'(tx_if.tx_arp_data), 512'(0));
      chk("rst_drop", 512'(ack_drop), 512'(0));

      // Periodic request: timer wraps after P edges, frame starts one edge later
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      rst = 1'b0;
      wait_vld(lat);
      chk("first_req_latency", 512'(lat), 512'(P + 1));
      resolved = 1'b1;
      drain();

      // Random replies under random back-pressure, occasional mid-frame cfg change
      rdy_mode = 2;
      d0 = drop_cnt;
      for (int it = 0; it < 8; it++) begin
         cmac = 48'({$urandom(), $urandom()});
         csip = $urandom();
         cdip = $urandom();
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) begin
            m  = 48'({$urandom(), $urandom()});
            ip = $urandom();
            exp_q.push_back(model_frame(1, m, ip, cmac, csip, cdip));
            send_ack(m, ip);
         end
         if (k == 1) begin
            wait_vld(lat);
            cmac = 48'({$urandom(), $urandom()});
            csip = $urandom();
         end
         drain();
      end
      chk("no_drops", 512'(drop_cnt - d0), 512'(0));

      // Overflow: stall a request frame, then overfill the reply queue
      rdy_mode = 0;
      tick(2);
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      req_en = 1'b1; tick(1); req_en = 1'b0;
      wait_vld(lat);
      d0 = drop_cnt;
      n0 = frames_rx;
      k = $urandom_range(5, 7);
      for (int j = 0; j < k; j++) begin
         m  = 48'({$urandom(), $urandom()});
         ip = $urandom();
         if (j < DEPTH) exp_q.push_back(model_frame(1, m, ip, cmac, csip, cdip));
         send_ack(m, ip);
      end
      tick(2);
      chk("drop_count", 512'(drop_cnt - d0), 512'(k - DEPTH));
      chk("stalled_no_frame", 512'(frames_rx - n0), 512'(0));
      rdy_mode = 1;
      drain();
      chk("overflow_frames", 512'(frames_rx - n0), 512'(DEPTH + 1));

      // Priority: reply before request, one idle cycle between them
      tick(3);
      m = 48'h001122334455; ip = 32'hC0A80002;
      exp_q.push_back(model_frame(1, m, ip, cmac, csip, cdip));
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      req_en = 1'b1;
      send_ack(m, ip);
      req_en = 1'b0;
      drain();
      gap = start_q[start_q.size() - 1] - end_q[end_q.size() - 2];
      chk("idle_gap", 512'(gap), 512'(2));

      // Suppression while resolved, then a single on-demand request
      n0 = frames_rx;
      tick(3 * P);
      chk("suppressed", 512'(frames_rx - n0), 512'(0));
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      req_en = 1'b1; tick(1); req_en = 1'b0;
      drain();
      tick(2 * P);
      chk("single_req", 512'(frames_rx - n0), 512'(1));

      // Reset mid-frame at beat 5
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      req_en = 1'b1; tick(1); req_en = 1'b0;
      k = 0;
      while (in_beats != 5 && k < 200) begin tick(1); k++; end
      chk("reach_beat5", 512'(in_beats), 512'(5));
      n0 = frames_rx;
      rst = 1'b1;
      tick(1);
      chk("abort_vld", 512'(tx_if.tx_arp_vld), 512'(0));
      chk("abort_eop", 512'(tx_if.tx_arp_eop), 512'(0));
      exp_q.delete();
      resolved = 1'b0;
      exp_q.push_back(model_frame(0, '0, '0, cmac, csip, cdip));
      rst = 1'b0;
      wait_vld(lat);
      chk("post_rst_latency", 512'(lat), 512'(P + 1));
      resolved = 1'b1;
      drain();
      chk("post_rst_frames", 512'(frames_rx - n0), 512'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule

`default_nettype wire
